entity_renderer: RTL and testbench
==================================

// Module: entity_renderer
// PURPOSE
//  Consumer of the entity position bus produced by the game-entities block: owns 640x480@60 VGA timing,
//  snapshots all entity positions once per frame (vblank) and rasterises ship, 5 enemies and both balls
//  into RGB. Sits between the entities block and the board VGA DAC; sole reader of the position bus.
// PARAMETERS
//  NAVE_W     45        ship width in pixels (ship drawn at x_nave..x_nave+NAVE_W-1)
//  NAVE_H     20        ship height in pixels
//  INIM_W     30        enemy width in pixels
//  INIM_H     20        enemy height in pixels
//  COR_FUNDO  24'h000000 background RGB;  COR_NAVE 24'h00FF00;  COR_INIM 24'hFF00FF
//  COR_BALIADA 24'hFFFFFF allied ball RGB; COR_BINIM 24'hFF0000 enemy ball RGB
// PORTS
//  CLOCK_50           in   1   50 MHz system clock
//  reset              in   1   asynchronous, active-high reset
//  x_bola_aliada      in  10   allied ball centre x;  y_bola_aliada in 10 centre y; raio_bola_aliada in 10 radius
//  x_bola_inimiga     in  10   enemy ball centre x;   y_bola_inimiga in 10 centre y; raio_bola_inimiga in 10 radius
//  x_nave, y_nave     in  10   ship top-left corner
//  inimigo_x          in  50   enemy i top-left x at [10i+9:10i], i=0..4
//  inimigo_y          in  50   enemy i top-left y at [10i+9:10i]
//  inimigo_vivo_array in   5   [0:4]; bit i=1 -> enemy i drawn
//  VGA_CLK            out  1   pixel-enable as 25 MHz clock (toggles every CLOCK_50)
//  VGA_HS, VGA_VS     out  1   active-low syncs
//  VGA_BLANK_N        out  1   1 during active video;  VGA_SYNC_N out 1 tied 0
//  VGA_R/G/B          out  8   colour, 0 outside active video
//  frame_start        out  1   one CLOCK_50 pulse when snapshot is taken
// BEHAVIOUR
//  - pix_en toggles every CLOCK_50 cycle; all counters/pipeline regs advance only when pix_en=1.
//  - hcnt 0..799 wraps to 0 and increments vcnt 0..524 (wraps to 0). Active: hcnt<640 && vcnt<480.
//  - HS low for hcnt 656..751; VS low for vcnt 490..491 (raw, before pipeline delay).
//  - Snapshot: on the pix_en tick with hcnt==0 && vcnt==480 all input positions/radii/vivo latch into
//    shadow regs; frame_start=1 that cycle. Inputs changing at any other time have no effect on the frame.
//  - Pipeline, 3 pix_en ticks from (hcnt,vcnt) to RGB pin; HS/VS/BLANK_N delayed identically:
//    S1 register 11-bit signed dx,dy per ball and in-range compares per rectangle;
//    S2 register dx*dx+dy*dy (21 bits) <= r*r hits, rectangle hits; S3 priority mux -> RGB reg.
//  - Rect hit: x0 <= px <= x0+W-1 and y0 <= py <= y0+H-1, sums in 11 bits (no wrap; off-screen
//    parts simply never match). Enemy i only if vivo[i]=1.
//  - Ball hit: dx^2+dy^2 <= r^2; r=0 draws only centre pixel.
//  - Priority: allied ball > enemy ball > ship > enemy 0..4 > background. Blank -> RGB=0.
//  - Reset (any time, async): hcnt=vcnt=0, pix_en=0, shadows=0 (vivo=0), pipeline cleared,
//    VGA_HS=VGA_VS=1, VGA_BLANK_N=0, RGB=0, frame_start=0. First snapshot at the first vcnt==480 after reset.
// TESTING
//  1 reset release, run 2 frames -> HS period 1600 CLOCK_50, low 192; VS period 840000, low 3200.
//  2 ship x=100,y=400; sample pixel(100,400) & (144,419) -> COR_NAVE; (145,400),(99,400) -> COR_FUNDO;
//    RGB appears exactly 3 pix_en after counter reaches pixel.
//  3 allied ball (320,240,r=5) over ship at (300,230) -> (320,240),(325,240) white; (324,244) ship green.
//  4 vivo=5'b00100 style: only enemy 2 at (200,50) drawn; enemy 0 at (20,40) with vivo=0 -> background.
//  5 change x_nave mid active video (vcnt=100) -> frame unchanged; new value drawn next frame; frame_start pulses once/frame.
//  6 assert reset at vcnt=300 -> syncs high, RGB 0 immediately; restart from hcnt=vcnt=0; x_nave=1020 -> no wrap to col 0.

Source files
------------

// File: rtl/entity_renderer.sv
// VGA renderer for the game entities: generates 640x480@60 timing, latches all entity
// positions once per frame during vblank and rasterises them through a 3-stage pipeline.
module entity_renderer #(
  parameter int          NAVE_W      = 45,
  parameter int          NAVE_H      = 20,
  parameter int          INIM_W      = 30,
  parameter int          INIM_H      = 20,
  parameter logic [23:0] COR_FUNDO   = 24'h000000,
  parameter logic [23:0] COR_NAVE    = 24'h00FF00,
  parameter logic [23:0] COR_INIM    = 24'hFF00FF,
  parameter logic [23:0] COR_BALIADA = 24'hFFFFFF,
  parameter logic [23:0] COR_BINIM   = 24'hFF0000,
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [9:0]  x_bola_aliada,
  input  logic [9:0]  y_bola_aliada,
  input  logic [9:0]  raio_bola_aliada,
  input  logic [9:0]  x_bola_inimiga,
  input  logic [9:0]  y_bola_inimiga,
  input  logic [9:0]  raio_bola_inimiga,
  input  logic [9:0]  x_nave,
  input  logic [9:0]  y_nave,
  input  logic [49:0] inimigo_x,
  input  logic [49:0] inimigo_y,
  input  logic [0:4]  inimigo_vivo_array,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start
);

  localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Extent sums use 11 bits so objects hanging past column 1023 never wrap to column 0.
  function automatic logic inSpan(input logic [9:0] p, input logic [9:0] o, input logic [10:0] len);
    return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} <= ({1'b0, o} + len - 11'd1));
  endfunction

  function automatic logic signed [10:0] delta(input logic [9:0] p, input logic [9:0] c);
    return $signed({1'b0, p}) - $signed({1'b0, c});
  endfunction

  function automatic logic [19:0] square(input logic signed [10:0] d);
    logic [9:0] a;
    a = d[10] ? 10'(-d) : d[9:0];
    return 20'(a) * 20'(a);
  endfunction

  logic       r_pixEn;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       w_snap;

  assign w_snap      = r_pixEn && (r_hcnt == 10'd0) && (r_vcnt == V_ACT);
  assign frame_start = w_snap;
  assign VGA_CLK     = r_pixEn;
  assign VGA_SYNC_N  = 1'b0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_pixEn <= 1'b0;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_pixEn <= ~r_pixEn;
      if (r_pixEn) begin
        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
    end
  end

  logic [9:0]  r_xA, r_yA, r_rA, r_xE, r_yE, r_rE, r_xN, r_yN;
  logic [49:0] r_xI, r_yI;
  logic [0:4]  r_vivo;

  // Shadow copies: the whole frame is drawn from one consistent set of positions.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_xA   <= '0;
      r_yA   <= '0;
      r_rA   <= '0;
      r_xE   <= '0;
      r_yE   <= '0;
      r_rE   <= '0;
      r_xN   <= '0;
      r_yN   <= '0;
      r_xI   <= '0;
      r_yI   <= '0;
      r_vivo <= '0;
    end else if (w_snap) begin
      r_xA   <= x_bola_aliada;
      r_yA   <= y_bola_aliada;
      r_rA   <= raio_bola_aliada;
      r_xE   <= x_bola_inimiga;
      r_yE   <= y_bola_inimiga;
      r_rE   <= raio_bola_inimiga;
      r_xN   <= x_nave;
      r_yN   <= y_nave;
      r_xI   <= inimigo_x;
      r_yI   <= inimigo_y;
      r_vivo <= inimigo_vivo_array;
    end
  end

  logic signed [10:0] r1_dxA, r1_dyA, r1_dxE, r1_dyE;
  logic               r1_nxOk, r1_nyOk;
  logic [4:0]         r1_ixOk, r1_iyOk;
  logic               r1_act, r1_hs, r1_vs;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r1_dxA  <= '0;
      r1_dyA  <= '0;
      r1_dxE  <= '0;
      r1_dyE  <= '0;
      r1_nxOk <= 1'b0;
      r1_nyOk <= 1'b0;
      r1_ixOk <= '0;
      r1_iyOk <= '0;
      r1_act  <= 1'b0;
      r1_hs   <= 1'b1;
      r1_vs   <= 1'b1;
    end else if (r_pixEn) begin
      r1_dxA  <= delta(r_hcnt, r_xA);
      r1_dyA  <= delta(r_vcnt, r_yA);
      r1_dxE  <= delta(r_hcnt, r_xE);
      r1_dyE  <= delta(r_vcnt, r_yE);
      r1_nxOk <= inSpan(r_hcnt, r_xN, 11'(NAVE_W));
      r1_nyOk <= inSpan(r_vcnt, r_yN, 11'(NAVE_H));
      for (int i = 0; i < 5; i++) begin
        r1_ixOk[i] <= r_vivo[i] && inSpan(r_hcnt, r_xI[10*i +: 10], 11'(INIM_W));
        r1_iyOk[i] <= inSpan(r_vcnt, r_yI[10*i +: 10], 11'(INIM_H));
      end
      r1_act  <= (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
      r1_hs   <= !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
      r1_vs   <= !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
    end
  end

  logic [20:0] w_distA, w_distE;
  logic [19:0] w_r2A, w_r2E;

  assign w_distA = 21'(square(r1_dxA)) + 21'(square(r1_dyA));
  assign w_distE = 21'(square(r1_dxE)) + 21'(square(r1_dyE));
  assign w_r2A   = 20'(r_rA) * 20'(r_rA);
  assign w_r2E   = 20'(r_rE) * 20'(r_rE);

  logic       r2_hitA, r2_hitE, r2_hitN;
  logic [4:0] r2_hitI;
  logic       r2_act, r2_hs, r2_vs;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r2_hitA <= 1'b0;
      r2_hitE <= 1'b0;
      r2_hitN <= 1'b0;
      r2_hitI <= '0;
      r2_act  <= 1'b0;
      r2_hs   <= 1'b1;
      r2_vs   <= 1'b1;
    end else if (r_pixEn) begin
      r2_hitA <= (w_distA <= {1'b0, w_r2A});
      r2_hitE <= (w_distE <= {1'b0, w_r2E});
      r2_hitN <= r1_nxOk && r1_nyOk;
      r2_hitI <= r1_ixOk & r1_iyOk;
      r2_act  <= r1_act;
      r2_hs   <= r1_hs;
      r2_vs   <= r1_vs;
    end
  end

  logic [23:0] w_color;

  always_comb begin
    w_color = COR_FUNDO;
    if (r2_hitA)        w_color = COR_BALIADA;
    else if (r2_hitE)   w_color = COR_BINIM;
    else if (r2_hitN)   w_color = COR_NAVE;
    else if (|r2_hitI)  w_color = COR_INIM;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (r_pixEn) begin
      VGA_HS               <= r2_hs;
      VGA_VS               <= r2_vs;
      VGA_BLANK_N          <= r2_act;
      {VGA_R, VGA_G, VGA_B} <= r2_act ? w_color : 24'h000000;
    end
  end

endmodule

// File: tb/tb_entity_renderer.sv
// Scoreboard bench for entity_renderer on a reduced screen geometry: a pixel-level model
// predicts every output pixel and sync level, a monitor compares them three pixel ticks later.
module tb_entity_renderer;

  localparam int H_ACT = 80, H_FP = 4, H_SY = 8, H_BP = 4, H_TOT = 96;
  localparam int V_ACT = 56, V_FP = 3, V_SY = 2, V_BP = 3, V_TOT = 64;
  localparam int NW = 45, NH = 20, IW = 30, IH = 20;
  localparam logic [23:0] C_FUNDO = 24'h000000, C_NAVE = 24'h00FF00, C_INIM = 24'hFF00FF;
  localparam logic [23:0] C_BAL = 24'hFFFFFF, C_BIN = 24'hFF0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  xA = '0, yA = '0, rA = '0, xE = '0, yE = '0, rE = '0, xN = '0, yN = '0;
  logic [49:0] inX = '0, inY = '0;
  logic [0:4]  vivo = '0;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  entity_renderer #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP)
  ) dut (
    .CLOCK_50(clk), .reset(reset),
    .x_bola_aliada(xA), .y_bola_aliada(yA), .raio_bola_aliada(rA),
    .x_bola_inimiga(xE), .y_bola_inimiga(yE), .raio_bola_inimiga(rE),
    .x_nave(xN), .y_nave(yN),
    .inimigo_x(inX), .inimigo_y(inY), .inimigo_vivo_array(vivo),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          h;
    int          v;
    logic [26:0] e;
  } exp_t;
  exp_t q[$];

  bit mPix = 1'b0;
  int mh = 0, mv = 0, snapCount = 0, fsCount = 0;
  int sxA = 0, syA = 0, srA = 0, sxE = 0, syE = 0, srE = 0, sxN = 0, syN = 0;
  int sxI[5], syI[5];
  bit sVivo[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit inRect(int px, int py, int x0, int y0, int w, int h);
    return px >= x0 && px <= x0 + w - 1 && py >= y0 && py <= y0 + h - 1;
  endfunction

  function automatic bit inBall(int px, int py, int xc, int yc, int r);
    return (px - xc) * (px - xc) + (py - yc) * (py - yc) <= r * r;
  endfunction

  function automatic logic [23:0] expColor(int px, int py);
    if (inBall(px, py, sxA, syA, srA)) return C_BAL;
    if (inBall(px, py, sxE, syE, srE)) return C_BIN;
    if (inRect(px, py, sxN, syN, NW, NH)) return C_NAVE;
    for (int i = 0; i < 5; i++)
      if (sVivo[i] && inRect(px, py, sxI[i], syI[i], IW, IH)) return C_INIM;
    return C_FUNDO;
  endfunction

  // Reference model: walks the raster, predicts each pixel and latches the frame snapshot.
  always @(posedge clk or posedge reset) begin
    exp_t t;
    bit act, hsE, vsE;
    if (reset) begin
      mPix = 1'b0; mh = 0; mv = 0;
      sxA = 0; syA = 0; srA = 0; sxE = 0; syE = 0; srE = 0; sxN = 0; syN = 0;
      for (int i = 0; i < 5; i++) begin sxI[i] = 0; syI[i] = 0; sVivo[i] = 1'b0; end
      q.delete();
    end else begin
      if (mPix) begin
        act = (mh < H_ACT) && (mv < V_ACT);
        hsE = !(mh >= H_ACT + H_FP && mh < H_ACT + H_FP + H_SY);
        vsE = !(mv >= V_ACT + V_FP && mv < V_ACT + V_FP + V_SY);
        t.h = mh;
        t.v = mv;
        t.e = {(act ? expColor(mh, mv) : 24'h000000), hsE, vsE, act};
        q.push_back(t);
        if (mh == 0 && mv == V_ACT) begin
          sxA = xA; syA = yA; srA = rA; sxE = xE; syE = yE; srE = rE; sxN = xN; syN = yN;
          for (int i = 0; i < 5; i++) begin
            sxI[i] = inX[10*i +: 10]; syI[i] = inY[10*i +: 10]; sVivo[i] = vivo[i];
          end
          snapCount++;
        end
        mh++;
        if (mh == H_TOT) begin
          mh = 0;
          mv = (mv + 1) % V_TOT;
        end
      end
      mPix = !mPix;
    end
  end

  int   cyc = 0, hsFall = -1, vsFall = -1;
  logic prevHs = 1'b1, prevVs = 1'b1;

  // Monitor: compares DUT pins against the scoreboard and measures sync periods.
  always @(negedge clk) begin
    exp_t t;
    if (reset) begin
      cyc = 0; hsFall = -1; vsFall = -1; prevHs = 1'b1; prevVs = 1'b1;
    end else begin
      cyc++;
      checkOutput("vga_clk", VGA_CLK, mPix);
      checkOutput("frame_start", frame_start, (mPix && mh == 0 && mv == V_ACT));
      if (frame_start) fsCount++;
      if (q.size() >= 3) begin
        t = q.pop_front();
        checkOutput($sformatf("pixel(%0d,%0d)", t.h, t.v),
                    {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, t.e);
      end
      if (prevHs && !VGA_HS) begin
        if (hsFall >= 0) checkOutput("hs_period", cyc - hsFall, 2 * H_TOT);
        hsFall = cyc;
      end
      if (!prevHs && VGA_HS && hsFall >= 0) checkOutput("hs_low", cyc - hsFall, 2 * H_SY);
      if (prevVs && !VGA_VS) begin
        if (vsFall >= 0) checkOutput("vs_period", cyc - vsFall, 2 * H_TOT * V_TOT);
        vsFall = cyc;
      end
      if (!prevVs && VGA_VS && vsFall >= 0) checkOutput("vs_low", cyc - vsFall, 2 * H_TOT * V_SY);
      prevHs = VGA_HS;
      prevVs = VGA_VS;
    end
  end

  task automatic applyStimulus(input int xa, input int ya, input int ra, input int xe, input int ye,
                               input int re, input int xn, input int yn,
                               input logic [49:0] ix, input logic [49:0] iy, input logic [0:4] v);
    xA = 10'(xa); yA = 10'(ya); rA = 10'(ra);
    xE = 10'(xe); yE = 10'(ye); rE = 10'(re);
    xN = 10'(xn); yN = 10'(yn);
    inX = ix; inY = iy; vivo = v;
  endtask

  function automatic int rc(int maxv);
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(960, 1023));
    return int'($urandom_range(0, maxv));
  endfunction

  task automatic randomStimulus();
    logic [49:0] ix, iy;
    logic [0:4]  v;
    for (int i = 0; i < 5; i++) begin
      ix[10*i +: 10] = 10'(rc(95));
      iy[10*i +: 10] = 10'(rc(70));
    end
    v = 5'($urandom_range(0, 31));
    applyStimulus(rc(95), rc(70), int'($urandom_range(0, 20)), rc(95), rc(70),
                  int'($urandom_range(0, 20)), rc(95), rc(70), ix, iy, v);
  endtask

  task automatic waitRow(input int row);
    int n = 0;
    while (mv != row && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (mv != row) checkOutput("wait_row", mv, row);
  endtask

  task automatic waitSnap(input int cnt);
    int n = 0;
    while (snapCount < cnt && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (snapCount < cnt) checkOutput("wait_snap", snapCount, cnt);
  endtask

  task automatic checkResetState();
    checkOutput("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    checkOutput("rst_hs", VGA_HS, 1'b1);
    checkOutput("rst_vs", VGA_VS, 1'b1);
    checkOutput("rst_blank_n", VGA_BLANK_N, 1'b0);
    checkOutput("rst_frame_start", frame_start, 1'b0);
    checkOutput("rst_vga_clk", VGA_CLK, 1'b0);
    checkOutput("rst_sync_n", VGA_SYNC_N, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1000, 1000, 0, 1010, 1010, 0, 10, 30, 50'd0, 50'd0, 5'b00000);
    repeat (3) @(negedge clk);
    #1 checkResetState();
    @(negedge clk);
    #5 reset = 1'b0;

    waitSnap(1);
    waitRow(10);
    applyStimulus(30, 25, 6, 36, 25, 5, 20, 20,
                  {10'd0, 10'd50, 10'd0, 10'd0, 10'd25},
                  {10'd0, 10'd35, 10'd0, 10'd0, 10'd30}, 5'b10010);

    waitSnap(2);
    waitRow(10);
    applyStimulus(70, 2, 8, 5, 50, 0, 1020, 10,
                  {10'd0, 10'd0, 10'd40, 10'd0, 10'd2},
                  {10'd0, 10'd0, 10'd5, 10'd0, 10'd4}, 5'b00100);

    waitSnap(3);
    waitRow(5);
    randomStimulus();
    waitRow(20);
    randomStimulus();
    waitRow(40);
    randomStimulus();

    waitSnap(4);
    waitRow(10);
    randomStimulus();
    waitRow(30);
    #5 reset = 1'b1;
    #1 checkResetState();
    repeat (3) @(negedge clk);
    #5 reset = 1'b0;

    waitRow(40);
    repeat (10) @(negedge clk);
    checkOutput("frame_start_count", fsCount, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
